// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 width/sign codes for RISC-V loads and stores
//   - FSM state enum (IDLE, BUS)
//   - fault cause encodings reported on o_fault_cause
package lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_LOAD_MISALIGN  = 2'd0,
    FAULT_STORE_MISALIGN = 2'd1,
    FAULT_BUS_ERR        = 2'd2,
    FAULT_ILLEGAL        = 2'd3
  } lsu_fault_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Request side (from the incoming instruction):
//   is_load_i, is_store_i, funct3_i, addr_lo_i, st_data_i
//   -> sel_o (byte lanes), wdata_o (replicated store data),
//      misalign_o, illegal_o
// Response side (from the registered bus request):
//   ld_funct3_i, ld_addr_lo_i, rdata_i -> ld_data_o (extracted, extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane;

  always_comb begin
    sel_o      = '0;
    wdata_o    = st_data_i;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;

    // Width comes from funct3[1:0]; funct3[2] only marks unsigned loads.
    case (funct3_i[1:0])
      2'b00: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        sel_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{st_data_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      2'b10: begin
        sel_o      = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: sel_o = '0;
    endcase

    if (is_load_i) begin
      illegal_o = !(funct3_i inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
    end else if (is_store_i) begin
      illegal_o = !(funct3_i inside {MEM_B, MEM_H, MEM_W});
    end

    // An illegal encoding is reported as such, never as misaligned.
    if (illegal_o) begin
      misalign_o = 1'b0;
    end
  end

  always_comb begin
    lane = rdata_i >> {ld_addr_lo_i, 3'b000};
    case (ld_funct3_i)
      MEM_B:   ld_data_o = {{24{lane[7]}}, lane[7:0]};
      MEM_H:   ld_data_o = {{16{lane[15]}}, lane[15:0]};
      MEM_BU:  ld_data_o = {24'h0, lane[7:0]};
      MEM_HU:  ld_data_o = {16'h0, lane[15:0]};
      default: ld_data_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: drives a single-master classic Wishbone bus for loads and
// stores, passes non-memory results through, and presents one registered
// result per instruction to writeback.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_valid / o_ready               instruction handshake from execute
//   i_alu_out, i_store_data         effective address / result, rs2 value
//   i_is_load, i_is_store, i_funct3 instruction kind and width/sign
//   i_rd                            destination register
//   o_wb_*, i_wb_*                  Wishbone master interface
//   o_valid, o_rd, o_result         writeback result pulse
//   o_fault, o_fault_cause          trap qualification and cause
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_alu_out,
  input  logic [31:0]       i_store_data,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-3:0] o_wb_adr,
  output logic [31:0]       o_wb_dat,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [31:0]       i_wb_dat,
  output logic              o_valid,
  output logic [REG_W-1:0]  o_rd,
  output logic [31:0]       o_result,
  output logic              o_fault,
  output logic [1:0]        o_fault_cause
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-3:0] adr_q, adr_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  lsu_fault_e        cause_q, cause_d;
  logic [31:0]       result_q, result_d;
  logic [REG_W-1:0]  rd_out_q, rd_out_d;
  logic              mem_done_q, mem_done_d;

  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [31:0] ld_data;
  logic        misalign;
  logic        illegal;
  logic        is_mem;
  logic        accept;
  logic        bus_active;

  lsu_align u_align (
    .is_load_i    (i_is_load),
    .is_store_i   (i_is_store),
    .funct3_i     (i_funct3),
    .addr_lo_i    (i_alu_out[1:0]),
    .st_data_i    (i_store_data),
    .sel_o        (req_sel),
    .wdata_o      (req_wdata),
    .misalign_o   (misalign),
    .illegal_o    (illegal),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (lo_q),
    .rdata_i      (i_wb_dat),
    .ld_data_o    (ld_data)
  );

  // mem_done_q blocks a new accept in the cycle a memory op reports back.
  assign o_ready    = (state_q == IDLE) && !mem_done_q;
  assign accept     = i_valid && o_ready;
  assign is_mem     = i_is_load || i_is_store;
  assign bus_active = (state_q == BUS);

  assign o_wb_cyc      = bus_active;
  assign o_wb_stb      = bus_active;
  assign o_wb_we       = bus_active && we_q;
  assign o_wb_adr      = bus_active ? adr_q : '0;
  assign o_wb_dat      = bus_active ? dat_q : '0;
  assign o_wb_sel      = bus_active ? sel_q : '0;
  assign o_valid       = valid_q;
  assign o_rd          = rd_out_q;
  assign o_result      = result_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    lo_d       = lo_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    cause_d    = FAULT_LOAD_MISALIGN;
    result_d   = result_q;
    rd_out_d   = rd_out_q;
    mem_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            valid_d  = 1'b1;
            result_d = i_alu_out;
            rd_out_d = i_rd;
          end else if (illegal || misalign) begin
            valid_d    = 1'b1;
            fault_d    = 1'b1;
            result_d   = '0;
            rd_out_d   = '0;
            mem_done_d = 1'b1;
            if (illegal) begin
              cause_d = FAULT_ILLEGAL;
            end else if (i_is_load) begin
              cause_d = FAULT_LOAD_MISALIGN;
            end else begin
              cause_d = FAULT_STORE_MISALIGN;
            end
          end else begin
            state_d = BUS;
            adr_d   = i_alu_out[ADDR_W-1:2];
            lo_d    = i_alu_out[1:0];
            dat_d   = req_wdata;
            sel_d   = req_sel;
            we_d    = i_is_store;
            f3_d    = i_funct3;
            rd_d    = i_is_store ? '0 : i_rd;
          end
        end
      end
      BUS: begin
        if (i_wb_err) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          fault_d    = 1'b1;
          cause_d    = FAULT_BUS_ERR;
          result_d   = '0;
          rd_out_d   = '0;
          mem_done_d = 1'b1;
        end else if (i_wb_ack) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          result_d   = we_q ? '0 : ld_data;
          rd_out_d   = rd_q;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      lo_q       <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FAULT_LOAD_MISALIGN;
      result_q   <= '0;
      rd_out_q   <= '0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      lo_q       <= lo_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
      mem_done_q <= mem_done_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_alu_out = '0;
  logic [31:0] i_store_data = '0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd = '0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [31:0] o_result;
  logic        o_fault;
  logic [1:0]  o_fault_cause;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .REG_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_out(i_alu_out), .i_store_data(i_store_data),
    .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_rd(i_rd),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
    .o_valid(o_valid), .o_rd(o_rd), .o_result(o_result),
    .o_fault(o_fault), .o_fault_cause(o_fault_cause)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int unsigned waits;
    logic        err;
    logic        ack;
    logic [4:0]  rd;
    logic        bus;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] res;
    logic [4:0]  erd;
    logic        fault;
    logic [1:0]  cause;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        chk_rd;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   tests = 0;
  int   failed = 0;

  function automatic vec_t mkv(
    input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [31:0] rdata, input int unsigned waits,
    input logic err, input logic ack, input logic [4:0] rd, input logic bus,
    input logic [3:0] sel, input logic [31:0] wdat, input logic [31:0] res,
    input logic [4:0] erd, input logic fault, input logic [1:0] cause);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.waits = waits; v.err = err; v.ack = ack; v.rd = rd; v.bus = bus; v.sel = sel;
    v.wdat = wdat; v.res = res; v.erd = erd; v.fault = fault; v.cause = cause;
    return v;
  endfunction

  task automatic chk(input string t, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", t, f, act, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (o_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("monitor", "unexpected_valid", {31'h0, o_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("monitor", "result", o_result, e.res);
        chk("monitor", "fault", {31'h0, o_fault}, {31'h0, e.fault});
        if (e.fault) chk("monitor", "cause", {30'h0, o_fault_cause}, {30'h0, e.cause});
        if (e.chk_rd) chk("monitor", "rd", {27'h0, o_rd}, {27'h0, e.rd});
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    chk(tag, "ready_idle", {31'h0, o_ready}, 32'h1);
    i_valid = 1'b1; i_alu_out = v.addr; i_store_data = v.sdata;
    i_is_load = v.ld; i_is_store = v.st; i_funct3 = v.f3; i_rd = v.rd;
    e.res = v.res; e.rd = v.erd; e.chk_rd = !v.fault; e.fault = v.fault; e.cause = v.cause;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_alu_out = 32'hA5A5_0000; i_store_data = 32'h0;
    if (v.bus) begin
      for (int unsigned w = 0; w <= v.waits; w++) begin
        @(negedge clk);
        chk(tag, "cyc", {31'h0, o_wb_cyc}, 32'h1);
        chk(tag, "stb", {31'h0, o_wb_stb}, 32'h1);
        chk(tag, "we", {31'h0, o_wb_we}, {31'h0, v.st});
        chk(tag, "adr", {2'b00, o_wb_adr}, {2'b00, v.addr[31:2]});
        chk(tag, "sel", {28'h0, o_wb_sel}, {28'h0, v.sel});
        if (v.st) chk(tag, "dat", o_wb_dat, v.wdat);
        chk(tag, "ready_bus", {31'h0, o_ready}, 32'h0);
        chk(tag, "valid_bus", {31'h0, o_valid}, 32'h0);
        if (w == v.waits) begin
          i_wb_ack = v.ack; i_wb_err = v.err; i_wb_dat = v.rdata;
        end
      end
      @(posedge clk);
      #1;
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'hDEAD_0000;
    end
    @(negedge clk);
    chk(tag, "valid_pulse", {31'h0, o_valid}, 32'h1);
    chk(tag, "ready_after", {31'h0, o_ready}, {31'h0, !(v.ld || v.st)});
    chk(tag, "cyc_after", {31'h0, o_wb_cyc}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                ld st f3      addr          sdata         rdata         w  er ak rd bus sel      wdat          res           erd flt cause
    vecs[0]  = mkv(0, 0, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 7,  0, 4'b0000, 32'h0,        32'h1234_5678, 7,  0, 2'd0);
    vecs[1]  = mkv(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 1, 5,  1, 4'b1000, 32'h0,        32'hFFFF_FF80, 5,  0, 2'd0);
    vecs[2]  = mkv(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 1, 6,  1, 4'b1000, 32'h0,        32'h0000_0080, 6,  0, 2'd0);
    vecs[3]  = mkv(0, 1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        3, 0, 1, 9,  1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0,  0, 2'd0);
    vecs[4]  = mkv(1, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 3,  0, 4'b0000, 32'h0,        32'h0,        0,  1, 2'd0);
    vecs[5]  = mkv(0, 1, 3'b001, 32'h0000_0001, 32'h1111_2222, 32'h0,        0, 0, 0, 3,  0, 4'b0000, 32'h0,        32'h0,        0,  1, 2'd1);
    vecs[6]  = mkv(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 3,  0, 4'b0000, 32'h0,        32'h0,        0,  1, 2'd3);
    vecs[7]  = mkv(1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h0000_0055, 0, 1, 1, 4,  1, 4'b1111, 32'h0,        32'h0,        0,  1, 2'd2);
    vecs[8]  = mkv(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 0, 1, 10, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 10, 0, 2'd0);
    vecs[9]  = mkv(1, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F234, 0, 0, 1, 11, 1, 4'b0011, 32'h0,        32'h0000_F234, 11, 0, 2'd0);
    vecs[10] = mkv(0, 1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0,        1, 0, 1, 8,  1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0,  0, 2'd0);
    vecs[11] = mkv(0, 1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        0, 1, 0, 8,  1, 4'b1111, 32'hCAFE_F00D, 32'h0,        0,  1, 2'd2);
    vecs[12] = mkv(1, 0, 3'b010, 32'h0000_0404, 32'h0,        32'h1122_3344, 2, 0, 1, 12, 1, 4'b1111, 32'h0,        32'h1122_3344, 12, 0, 2'd0);
    vecs[13] = mkv(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 0, 1, 13, 1, 4'b0010, 32'h0,        32'h0000_007F, 13, 0, 2'd0);
    vecs[14] = mkv(0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 3,  0, 4'b0000, 32'h0,        32'h0,        0,  1, 2'd3);
    vecs[15] = mkv(1, 0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        0, 0, 0, 3,  0, 4'b0000, 32'h0,        32'h0,        0,  1, 2'd0);
    vecs[16] = mkv(0, 0, 3'b011, 32'hFFFF_FFFF, 32'h0,        32'h0,        0, 0, 0, 31, 0, 4'b0000, 32'h0,        32'hFFFF_FFFF, 31, 0, 2'd0);

    #1 rst_n = 1'b0;
    #11;
    chk("reset", "valid", {31'h0, o_valid}, 32'h0);
    chk("reset", "cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("reset", "stb", {31'h0, o_wb_stb}, 32'h0);
    chk("reset", "we", {31'h0, o_wb_we}, 32'h0);
    chk("reset", "adr", {2'b00, o_wb_adr}, 32'h0);
    chk("reset", "sel", {28'h0, o_wb_sel}, 32'h0);
    chk("reset", "dat", o_wb_dat, 32'h0);
    chk("reset", "result", o_result, 32'h0);
    chk("reset", "rd", {27'h0, o_rd}, 32'h0);
    chk("reset", "fault", {31'h0, o_fault}, 32'h0);
    chk("reset", "cause", {30'h0, o_fault_cause}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a load is waiting on the bus: cycle drops immediately,
    // the instruction never reports back.
    @(negedge clk);
    i_valid = 1'b1; i_alu_out = 32'h0000_0100; i_is_load = 1'b1; i_funct3 = 3'b010; i_rd = 5'd20;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_is_load = 1'b0;
    @(negedge clk);
    chk("midrst", "cyc_before", {31'h0, o_wb_cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst", "cyc_async", {31'h0, o_wb_cyc}, 32'h0);
    chk("midrst", "stb_async", {31'h0, o_wb_stb}, 32'h0);
    chk("midrst", "valid_async", {31'h0, o_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst", "no_valid", {31'h0, o_valid}, 32'h0);
      chk("midrst", "no_cyc", {31'h0, o_wb_cyc}, 32'h0);
    end
    run_vec(vecs[12], "post_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard", "pending", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU; consumes the ALU result as effective address (loads/stores) or passes it through (all other ops).
- Drives a single-master classic Wishbone bus, aligns store data and byte selects, and sign/zero-extends load data.
- Presents one registered result per instruction to writeback.
- Back-pressures execute while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width; bus address is ADDR_W-2 word bits.
- REG_W, 5, destination register index width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute presents an instruction
- o_ready  out  1  unit can accept; transfer on i_valid && o_ready
- i_alu_out  in  32  ALU result / effective address
- i_store_data  in  32  rs2 value
- i_is_load  in  1  load instruction
- i_is_store  in  1  store instruction (mutually exclusive with i_is_load)
- i_funct3  in  3  RISC-V width/sign field
- i_rd  in  REG_W  destination register
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control
- o_wb_adr  out  ADDR_W-2  word address
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte lane selects
- i_wb_ack, i_wb_err  in  1 each  Wishbone termination
- i_wb_dat  in  32  read data
- o_valid  out  1  single-cycle result pulse to writeback (no back-pressure)
- o_rd  out  REG_W  destination register
- o_result  out  32  writeback value
- o_fault  out  1  qualifies o_valid; instruction trapped
- o_fault_cause  out  2  see package encodings

Behaviour:
- Reset: i_rst_n low forces state IDLE; all Wishbone outputs, o_valid, o_fault, o_result, o_rd and o_fault_cause go to 0 asynchronously. Reset mid-transaction drops o_wb_cyc immediately and discards the instruction.
- State IDLE: o_ready=1.
  - Accepted non-memory op: next cycle o_valid=1, o_result=i_alu_out, o_rd=i_rd. Latency 1.
  - Accepted memory op, aligned and legal: register address, data, sel and funct3; enter BUS.
  - Accepted memory op, misaligned or illegal: no bus cycle; next cycle o_valid=1, o_fault=1, o_result=0, with the cause set.
- State BUS: o_ready=0. o_wb_cyc=o_wb_stb=1 and all bus outputs held stable until termination.
  - On an edge with i_wb_ack=1: drop cyc/stb, o_valid=1 next cycle, return to IDLE.
  - Load o_result = extended data. Store o_result = 0, o_rd forced to 0.
  - i_wb_err=1, or ack and err together (err wins): o_valid with o_fault=1 and bus-error cause.
- Minimum memory latency: accept edge, one BUS cycle, result on the following cycle. Zero-wait ack means o_valid 2 cycles after accept.
- No new accept in the cycle o_valid is asserted for a memory op; IDLE resumes the cycle after the ack edge.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Anything else is illegal.
- o_wb_sel: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- o_wb_dat: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- Load extract: the selected lane shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- o_wb_adr = addr[ADDR_W-1:2]. Outputs are Wishbone-idle whenever o_wb_cyc=0 (stb=we=0).

Decomposition:
- Package lsu_pkg holds:
  - funct3 width constants: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - state enum: IDLE, BUS.
  - fault cause enum: FAULT_LOAD_MISALIGN=0, FAULT_STORE_MISALIGN=1, FAULT_BUS_ERR=2, FAULT_ILLEGAL=3.
- Sub-module lsu_align (combinational) handles sel generation, store replication, load extraction/extension, and the misalign/illegal flags. The top level owns the FSM and registers.

Test Plan:
- Non-memory op, i_alu_out=0x1234_5678, rd=7 -> o_valid one cycle later, o_result=0x1234_5678, o_rd=7, no o_wb_cyc.
- LB addr 0x103, zero-wait ack, i_wb_dat=0x80FF_FFFF -> adr=0x40, sel=1000, o_result=0xFFFF_FF80 two cycles after accept. Same with LBU -> 0x0000_0080.
- SH addr 0x202, data 0xDEAD_BEEF, ack after 3 wait cycles -> we=1, sel=1100, dat=0xBEEF_BEEF held stable for all 4 BUS cycles; o_ready=0 throughout; o_valid with rd=0.
- LW addr 0x6 -> no bus cycle, o_valid with o_fault=1, cause=0. SH addr 0x1 -> cause=1. Load funct3=011 -> cause=3.
- LW with ack and err together -> o_fault=1, cause=2.
- Assert i_rst_n=0 mid-BUS -> o_wb_cyc falls without a clock edge, no o_valid after release, and a fresh op is accepted normally.
